// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, constants and fetch FSM state type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef enum logic {FETCH_RUN, FETCH_HALTED} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// if_id_register: IF/ID pipeline register, bubble over load, holds otherwise
module if_id_register
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = cpu_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);
  always_ff @(posedge clk or posedge reset)
    if (reset || bubble) begin
      pc    <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, halt FSM and redirect/stall priority feeding IF/ID
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC         = cpu_pkg::RESET_PC,
  parameter int              NUM_INSTRUCTIONS = 3,
  parameter logic [XLEN-1:0] NOP_WORD         = cpu_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] mem_address,
  input  logic [XLEN-1:0] instruction_in,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic            halted,
  output logic            misaligned,
  output logic [XLEN-1:0] fetch_count
);
  localparam logic [XLEN-1:0] END_PC = XLEN'(NUM_INSTRUCTIONS * 4);
  fetch_state_t state;
  logic [XLEN-1:0] pc, target;
  logic running, past_end, fetch, bubble;
  always_comb begin
    target   = {redirect_target[XLEN-1:2], 2'b00};
    running  = state == FETCH_RUN;
    past_end = pc >= END_PC;
    fetch    = !redirect && running && !past_end && !stall;
    bubble   = redirect || !running || past_end;
  end
  assign mem_address = pc;
  assign halted      = state == FETCH_HALTED;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc          <= RESET_PC;
      state       <= FETCH_RUN;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc         <= target;
      misaligned <= misaligned || (redirect_target[1:0] != 2'b00);
      state      <= target < END_PC ? FETCH_RUN : FETCH_HALTED;
    end else if (running && past_end) begin
      state <= FETCH_HALTED;
    end else if (fetch) begin
      pc          <= pc + XLEN'(4);
      fetch_count <= fetch_count + {{(XLEN-1){1'b0}}, ~&fetch_count};
    end
  if_id_register #(.NOP(NOP_WORD)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (fetch),
    .bubble   (bubble),
    .pc_in    (pc),
    .instr_in (instruction_in),
    .pc       (if_id_pc),
    .instr    (if_id_instruction),
    .valid    (if_id_valid)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random checks against a spec-level fetch model
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] END_PC = 32'd12;
  logic clk = 1'b0;
  logic reset, stall, redirect;
  logic [31:0] redirect_target, mem_address, instruction_in, if_id_pc, if_id_instruction, fetch_count;
  logic if_id_valid, halted, misaligned;
  logic [31:0] imem [0:2];
  int passed = 0;
  int total = 0;
  logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
  logic m_halt, m_val, m_mis;
  always #5 clk = ~clk;
  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .mem_address       (mem_address),
    .instruction_in    (instruction_in),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .misaligned        (misaligned),
    .fetch_count       (fetch_count)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a < END_PC ? imem[a[3:2]] : (32'hBAD0_0000 ^ a);
  endfunction
  assign instruction_in = mem_word(mem_address);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic check_all(input string tag);
    chk({tag, " mem_address"}, mem_address, m_pc);
    chk({tag, " if_id_pc"}, if_id_pc, m_ipc);
    chk({tag, " if_id_instruction"}, if_id_instruction, m_ins);
    chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, m_val});
    chk({tag, " halted"}, {31'b0, halted}, {31'b0, m_halt});
    chk({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, m_mis});
    chk({tag, " fetch_count"}, fetch_count, m_cnt);
  endtask
  task automatic model_reset();
    m_pc = 0; m_halt = 0; m_ipc = 0; m_ins = NOP; m_val = 0; m_mis = 0; m_cnt = 0;
  endtask
  task automatic model_bubble();
    m_ipc = 0; m_ins = NOP; m_val = 0;
  endtask
  task automatic model_edge();
    if (redirect) begin
      m_pc = redirect_target & ~32'd3;
      model_bubble();
      if (redirect_target[1:0] != 0) m_mis = 1;
      m_halt = m_pc >= END_PC;
    end else if (m_halt) model_bubble();
    else if (m_pc >= END_PC) begin
      m_halt = 1;
      model_bubble();
    end else if (!stall) begin
      m_ipc = m_pc; m_ins = mem_word(m_pc); m_val = 1;
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 reset = 1;
    model_reset();
    #1 check_all(tag);
    reset = 0;
  endtask
  initial begin
    imem[0] = 32'h00500093; imem[1] = 32'h00A00113; imem[2] = 32'h002081B3;
    reset = 1; stall = 0; redirect = 0; redirect_target = 0;
    model_reset();
    #1 check_all("reset");
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 4; i++) tick("run");
    chk("halt count", fetch_count, 32'd3);
    chk("halt addr", mem_address, 32'd12);
    tick("halted hold");
    async_reset("rst2");
    tick("pre-stall");
    stall = 1;
    tick("stall1");
    tick("stall2");
    chk("stall ifid instr", if_id_instruction, 32'h00500093);
    stall = 0;
    tick("unstall");
    chk("unstall ifid pc", if_id_pc, 32'd4);
    async_reset("rst3");
    tick("pre-redir");
    stall = 1; redirect = 1; redirect_target = 8;
    tick("redir stalled");
    stall = 0; redirect = 0;
    tick("redir fetch");
    chk("redir ifid pc", if_id_pc, 32'd8);
    redirect = 1; redirect_target = 32'h6;
    tick("misaligned redir");
    chk("misaligned pc", mem_address, 32'd4);
    redirect_target = 0;
    tick("redir after mis");
    redirect = 0;
    for (int i = 0; i < 4; i++) tick("to halt");
    redirect = 1; redirect_target = 0;
    tick("halted redir 0");
    redirect = 0;
    tick("halted resume");
    chk("resume valid", {31'b0, if_id_valid}, 32'd1);
    redirect = 1; redirect_target = 100;
    tick("redir 100");
    redirect = 0;
    tick("redir 100 hold");
    async_reset("rst4");
    tick("to pc4");
    tick("to pc8");
    async_reset("async mid");
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) async_reset("rand reset");
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 7))
        0: redirect_target = 0;
        1: redirect_target = 4;
        2: redirect_target = 8;
        3: redirect_target = 12;
        4: redirect_target = 32'h0000_0006;
        5: redirect_target = 32'hFFFF_FFFC;
        6: redirect_target = 32'h0000_0001;
        default: redirect_target = $urandom;
      endcase
      tick("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
